// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: load-use stall, redirect flush and registered EX forwarding selects for the ID/EX stage.
// Optional HAZARD_PERF_EN adds 32-bit stall/flush cycle counters; without it both perf ports read 0.
module ex_hazard_ctrl #(
    parameter int AW           = 5,
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] id_rs1_addr,
    input  logic [AW-1:0] id_rs2_addr,
    input  logic          id_uses_rs1,
    input  logic          id_uses_rs2,
    input  logic [AW-1:0] ex_rd_addr,
    input  logic          ex_reg_wen,
    input  logic          ex_is_load,
    input  logic          ex_redirect,
    input  logic [AW-1:0] mem_rd_addr,
    input  logic          mem_reg_wen,
    output logic          stall_pc,
    output logic          stall_if_id,
    output logic          bubble_id_ex,
    output logic          flush_if_id,
    output logic [1:0]    fwd_a_sel,
    output logic [1:0]    fwd_b_sel,
    output logic [31:0]   perf_stall_cnt,
    output logic [31:0]   perf_flush_cnt
);
    typedef enum logic [1:0] {RUN, LSTALL, RDIR} state_t;

    localparam logic [2:0] LCNT = 3'(LOAD_LAT > 1 ? LOAD_LAT - 2 : 0);
    localparam logic [2:0] FCNT = 3'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0);

    state_t     state;
    logic [2:0] cnt;
    logic       hz_a, hz_b, mem_a, mem_b, load_use, stall, flush;

    assign hz_a     = id_uses_rs1 & ex_reg_wen & (ex_rd_addr != '0) & (ex_rd_addr == id_rs1_addr);
    assign hz_b     = id_uses_rs2 & ex_reg_wen & (ex_rd_addr != '0) & (ex_rd_addr == id_rs2_addr);
    assign mem_a    = id_uses_rs1 & mem_reg_wen & (mem_rd_addr != '0) & (mem_rd_addr == id_rs1_addr);
    assign mem_b    = id_uses_rs2 & mem_reg_wen & (mem_rd_addr != '0) & (mem_rd_addr == id_rs2_addr);
    assign load_use = ex_is_load & (hz_a | hz_b);

    // A redirect in any state wins over stalling; RDIR keeps flushing until its count runs out.
    assign flush        = ~rst & (ex_redirect | (state == RDIR));
    assign stall        = ~rst & ~ex_redirect & ((state == LSTALL) | ((state == RUN) & load_use));
    assign stall_pc     = stall;
    assign stall_if_id  = stall;
    assign flush_if_id  = flush;
    assign bubble_id_ex = stall | flush;

    // Sequencer: the first stall/flush cycle is spent in RUN, so the extra states hold N-1 more cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else if (ex_redirect) begin
            state <= (FLUSH_CYCLES > 1) ? RDIR : RUN;
            cnt   <= FCNT;
        end else if (state == RUN) begin
            if (load_use && (LOAD_LAT > 1)) begin
                state <= LSTALL;
                cnt   <= LCNT;
            end
        end else if (cnt == '0) begin
            state <= RUN;
        end else begin
            cnt <= cnt - 3'd1;
        end
    end

    // Forwarding selects travel with the ID/EX register; a bubble carries no operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_a_sel <= 2'b00;
            fwd_b_sel <= 2'b00;
        end else begin
            fwd_a_sel <= bubble_id_ex ? 2'b00 : (hz_a & ~ex_is_load) ? 2'b01 : mem_a ? 2'b10 : 2'b00;
            fwd_b_sel <= bubble_id_ex ? 2'b00 : (hz_b & ~ex_is_load) ? 2'b01 : mem_b ? 2'b10 : 2'b00;
        end
    end

`ifdef HAZARD_PERF_EN
    // Free-running cycle counters that wrap naturally at 32 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            perf_stall_cnt <= perf_stall_cnt + 32'(stall);
            perf_flush_cnt <= perf_flush_cnt + 32'(flush);
        end
    end
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif
endmodule
